i2c_passthru_bitrx: RTL

- Bit-level receiver for one side of the I2C passthru: watches SCL/SDA on the bus that currently owns the bit and decodes each SCL-high phase into init / mid-change / final SDA values for the bit transmitter on the other bus.
- Stretches SCL low on its own bus after every bit until the transmitter reports done and t_low has elapsed. Only releases SCL; never drives SDA.
- Sits between the pads and the bit transmitter; the main controller swaps which bus is rx per direction.

---
 rtl/i2c_passthru_bitrx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_passthru_bitrx.sv
`default_nettype none
// ============================================================================
// Module   : i2c_passthru_bitrx
// Purpose  : Bit-level I2C receiver for one side of the passthru. It decodes
//            each SCL-high phase into init / mid-change / final SDA values,
//            then holds SCL low until the far-side transmitter has finished
//            and the t_low minimum has elapsed. It never drives SDA.
// Options  : I2C_PASSTHRU_BITRX_GLITCH_FILT_EN enables a stability filter
//            on the SCL and SDA inputs.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_passthru_bitrx #(
    parameter int F_REF_T_LOW       = 38,
    parameter int WIDTH_F_REF_T_LOW = 6,
    parameter int GLITCH_CYCLES     = 3,
    parameter int WIDTH_GLITCH      = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_f_ref,
    input  logic i_scl,
    input  logic i_sda,
    input  logic i_tx_done,
    output logic o_scl,
    output logic o_sda_init_valid,
    output logic o_sda_init,
    output logic o_sda_mid_change,
    output logic o_sda_final,
    output logic o_rx_done,
    output logic o_start_det,
    output logic o_stop_det,
    output logic o_violation
);

    typedef enum logic [1:0] {
        ST_SCL1_HIGH = 2'd0,
        ST_STRETCH   = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_VIOLATION = 2'd3
    } state_t;

    // Reject counter widths that cannot hold their terminal values.
    if ((F_REF_T_LOW >= (1 << WIDTH_F_REF_T_LOW)) || (GLITCH_CYCLES < 1) ||
        (GLITCH_CYCLES >= (1 << WIDTH_GLITCH))) begin : g_param_check
        $error("i2c_passthru_bitrx: counter width too small for its parameter");
    end

    logic scl;
    logic sda;

`ifdef I2C_PASSTHRU_BITRX_GLITCH_FILT_EN
    logic                    scl_filt;
    logic                    sda_filt;
    logic [WIDTH_GLITCH-1:0] scl_cnt;
    logic [WIDTH_GLITCH-1:0] sda_cnt;

    // Accept a new input level only after it persists for GLITCH_CYCLES clocks.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
        end else begin
            if (i_scl == scl_filt) begin
                scl_cnt <= '0;
            end else if (scl_cnt == WIDTH_GLITCH'(GLITCH_CYCLES - 1)) begin
                scl_filt <= i_scl;
                scl_cnt  <= '0;
            end else begin
                scl_cnt <= scl_cnt + WIDTH_GLITCH'(1);
            end
            if (i_sda == sda_filt) begin
                sda_cnt <= '0;
            end else if (sda_cnt == WIDTH_GLITCH'(GLITCH_CYCLES - 1)) begin
                sda_filt <= i_sda;
                sda_cnt  <= '0;
            end else begin
                sda_cnt <= sda_cnt + WIDTH_GLITCH'(1);
            end
        end
    end

    assign scl = scl_filt;
    assign sda = sda_filt;
`else
    assign scl = i_scl;
    assign sda = i_sda;
`endif

    state_t                         state;
    state_t                         state_nx;
    logic [WIDTH_F_REF_T_LOW-1:0]   timer;
    logic [WIDTH_F_REF_T_LOW-1:0]   timer_nx;
    logic [1:0]                     change_cnt;
    logic [1:0]                     change_cnt_nx;
    logic                           f_ref_prev;
    logic                           f_ref_rise;
    logic                           tc;
    logic                           sda_edge;
    logic                           sda_init_nx;
    logic                           mid_change_nx;
    logic                           sda_final_nx;
    logic                           start_nx;
    logic                           stop_nx;

    assign f_ref_rise = i_f_ref & ~f_ref_prev;
    assign tc         = (timer == '0);
    // o_sda_final tracks sda one cycle late while SCL is high, so it doubles
    // as the previous-sample reference for edge detection.
    assign sda_edge   = (sda != o_sda_final);

    // Register all state and outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state            <= ST_SCL1_HIGH;
            timer            <= '0;
            change_cnt       <= '0;
            f_ref_prev       <= 1'b0;
            o_scl            <= 1'b1;
            o_sda_init_valid <= 1'b1;
            o_sda_init       <= 1'b1;
            o_sda_mid_change <= 1'b0;
            o_sda_final      <= 1'b1;
            o_rx_done        <= 1'b0;
            o_start_det      <= 1'b0;
            o_stop_det       <= 1'b0;
            o_violation      <= 1'b0;
        end else begin
            state            <= state_nx;
            timer            <= timer_nx;
            change_cnt       <= change_cnt_nx;
            f_ref_prev       <= i_f_ref;
            o_scl            <= (state_nx != ST_STRETCH);
            o_sda_init_valid <= (state_nx == ST_SCL1_HIGH);
            o_sda_init       <= sda_init_nx;
            o_sda_mid_change <= mid_change_nx;
            o_sda_final      <= sda_final_nx;
            o_rx_done        <= (state_nx == ST_STRETCH) || (state_nx == ST_RELEASE);
            o_start_det      <= start_nx;
            o_stop_det       <= stop_nx;
            o_violation      <= (state_nx == ST_VIOLATION);
        end
    end

    // Next-state, bit-decode and t_low timer logic.
    always_comb begin
        state_nx      = state;
        change_cnt_nx = change_cnt;
        sda_init_nx   = o_sda_init;
        mid_change_nx = o_sda_mid_change;
        sda_final_nx  = o_sda_final;
        start_nx      = 1'b0;
        stop_nx       = 1'b0;

        case (state)
            ST_SCL1_HIGH: begin
                sda_final_nx = sda;
                if (sda_edge) begin
                    mid_change_nx = 1'b1;
                    change_cnt_nx = (change_cnt == 2'd3) ? 2'd3 : change_cnt + 2'd1;
                    if (change_cnt >= 2'd2) begin
                        // A third edge in one high phase is not legal I2C.
                        state_nx = ST_VIOLATION;
                    end else begin
                        start_nx = ~sda;
                        stop_nx  = sda;
                    end
                end
                if ((state_nx != ST_VIOLATION) && !scl) begin
                    state_nx = ST_STRETCH;
                end
            end
            ST_STRETCH: begin
                if (i_tx_done && tc) begin
                    state_nx = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // SDA movement here is data setup; only the SCL rise matters.
                if (scl) begin
                    state_nx      = ST_SCL1_HIGH;
                    sda_init_nx   = sda;
                    sda_final_nx  = sda;
                    mid_change_nx = 1'b0;
                    change_cnt_nx = 2'd0;
                end
            end
            ST_VIOLATION: begin
                state_nx = ST_VIOLATION;
            end
            default: begin
                state_nx = ST_VIOLATION;
            end
        endcase

        if ((state_nx == ST_STRETCH) && (state != ST_STRETCH)) begin
            timer_nx = WIDTH_F_REF_T_LOW'(F_REF_T_LOW);
        end else if (f_ref_rise && !tc) begin
            timer_nx = timer - WIDTH_F_REF_T_LOW'(1);
        end else begin
            timer_nx = timer;
        end
    end

endmodule
`default_nettype wire
